// File: rtl/muldiv_hilo_seq_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer.
// Op codes match the core's decode; state codes are plain constants for legacy tools.
package muldiv_hilo_seq_pkg;

    localparam logic [1:0] OP_MULT  = 2'd0;
    localparam logic [1:0] OP_MULTU = 2'd1;
    localparam logic [1:0] OP_DIV   = 2'd2;
    localparam logic [1:0] OP_DIVU  = 2'd3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam int ITER = 32;

    function automatic logic op_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_hilo_seq_if.sv
// Request/result bundle between the control FSM (master) and the HI/LO sequencer (slave).
// Flow control is start/busy/stall; no credits.
interface muldiv_hilo_seq_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hilo_access;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             stall;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hilo_access, hi_we, lo_we, wdata,
        input  busy, done, stall, hi, lo
    );

    modport slave (
        input  start, op, a, b, hilo_access, hi_we, lo_we, wdata,
        output busy, done, stall, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo_seq_hilo_reg.sv
// HI/LO register pair: sequencer result or MTHI/MTLO write.
// Latency: writes land on the next edge. Backpressure: MT writes only when mt_en (sequencer idle).
module muldiv_hilo_seq_hilo_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fix_we,
    input  logic [WIDTH-1:0] fix_hi,
    input  logic [WIDTH-1:0] fix_lo,
    input  logic             mt_en,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (fix_we) begin
            hi_d = fix_hi;
            lo_d = fix_lo;
        end else if (mt_en) begin
            if (hi_we) hi_d = wdata;
            if (lo_we) lo_d = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/muldiv_hilo_seq.sv
// MULT/MULTU/DIV/DIVU sequencer owning HI/LO; radix-2 shift-add / restoring divide on magnitudes.
// Latency: start edge E0, HI/LO written and done raised at E33. Backpressure: stall holds start/MT* while busy.
module muldiv_hilo_seq
    import muldiv_hilo_seq_pkg::*;
#(
    parameter int WIDTH = ITER
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_hilo_seq_if.slave   bus
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               div_q, div_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic               neg_res_q, neg_res_d;
    logic               neg_rem_q, neg_rem_d;
    logic               done_q, done_d;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh, rem_diff;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_new;
    logic [2*WIDTH-1:0] mul_step, div_step, prod;
    logic [WIDTH-1:0]   quo, rem;
    logic               fix_we;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign a_neg = op_is_signed(bus.op) & bus.a[WIDTH-1];
    assign b_neg = op_is_signed(bus.op) & bus.b[WIDTH-1];
    assign a_mag = a_neg ? -bus.a : bus.a;
    assign b_mag = b_neg ? -bus.b : bus.b;

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    assign mul_step = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; borrow out of the trial subtract clears the quotient bit.
    assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    assign rem_diff = rem_sh - {1'b0, opnd_q};
    assign q_bit    = ~rem_diff[WIDTH];
    assign rem_new  = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign div_step = {rem_new, acc_q[WIDTH-2:0], q_bit};

    assign prod = neg_res_q ? -acc_q : acc_q;
    assign quo  = acc_q[WIDTH-1:0];
    assign rem  = acc_q[2*WIDTH-1:WIDTH];

    // A zero divisor yields an all-ones quotient; the remainder already equals the raw dividend.
    always_comb begin
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (div_q) begin
            fix_hi = neg_rem_q ? -rem : rem;
            if (opnd_q == '0)
                fix_lo = '1;
            else
                fix_lo = neg_res_q ? -quo : quo;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        acc_d     = acc_q;
        opnd_d    = opnd_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        done_d    = 1'b0;
        fix_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    div_d     = op_is_div(bus.op);
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    cnt_d     = '0;
                    state_d   = S_RUN;
                    if (op_is_div(bus.op)) begin
                        acc_d  = {{WIDTH{1'b0}}, a_mag};
                        opnd_d = b_mag;
                    end else begin
                        acc_d  = {{WIDTH{1'b0}}, b_mag};
                        opnd_d = a_mag;
                    end
                end
            end
            S_RUN: begin
                acc_d = div_q ? div_step : mul_step;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                fix_we  = 1'b1;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            acc_q     <= '0;
            opnd_q    <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            done_q    <= done_d;
        end
    end

    muldiv_hilo_seq_hilo_reg #(.WIDTH(WIDTH)) u_hilo (
        .clk    (clk),
        .rst    (rst),
        .fix_we (fix_we),
        .fix_hi (fix_hi),
        .fix_lo (fix_lo),
        .mt_en  (state_q == S_IDLE),
        .hi_we  (bus.hi_we),
        .lo_we  (bus.lo_we),
        .wdata  (bus.wdata),
        .hi     (bus.hi),
        .lo     (bus.lo)
    );

    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = done_q;
    assign bus.stall = bus.busy & (bus.start | bus.hilo_access);

endmodule

// File: tb/tb_muldiv_hilo_seq.sv
// Scoreboard bench for muldiv_hilo_seq: directed corners, MT/stall interplay, async reset, random ops.
module tb_muldiv_hilo_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv_hilo_seq_if #(.WIDTH(32)) bus ();
    muldiv_hilo_seq #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [31:0] m_hi     = '0;
    logic [31:0] m_lo     = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain 64-bit arithmetic with the architectural corner rules.
    function automatic logic [63:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sbv, q, r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (op == 2'd0) begin
            res = 64'(sa * sbv);
        end else if (op == 2'd1) begin
            res = {32'b0, a} * {32'b0, b};
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else begin
            if (op == 2'd2) begin
                q = sa / sbv;
                r = sa % sbv;
            end else begin
                q = longint'({32'b0, a}) / longint'({32'b0, b});
                r = longint'({32'b0, a}) % longint'({32'b0, b});
            end
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    function automatic logic [31:0] pick();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0:       return 32'h0000_0000;
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("result_hi", bus.hi, e.hi);
                chk("result_lo", bus.lo, e.lo);
                chk("done_cycle", cyc, e.due);
                chk("busy_with_done", 32'(bus.busy), 32'd0);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
        exp_t e;
        wait_idle();
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        e.hi  = ehi;
        e.lo  = elo;
        e.due = cyc + 34;
        sb.push_back(e);
        m_hi = ehi;
        m_lo = elo;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] prev_hi;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        logic [63:0] r;
        int          n;

        rst = 1'b1;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        bus.hilo_access = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        issue(2'd0, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
        issue(2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(2'd3, 32'd100,       32'd7,        32'd2,         32'd14);
        issue(2'd3, 32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF);
        issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000);
        issue(2'd2, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF);

        // MTHI+MTLO together while idle
        wait_idle();
        bus.hi_we = 1'b1; bus.lo_we = 1'b1; bus.wdata = 32'hCAFE_0001;
        @(negedge clk);
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        chk("mt_both_hi", bus.hi, 32'hCAFE_0001);
        chk("mt_both_lo", bus.lo, 32'hCAFE_0001);

        // MTLO coinciding with start: written now, overwritten by the result later
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_5555;
        issue(2'd3, 32'd50, 32'd5, 32'd0, 32'd10);
        bus.lo_we = 1'b0;
        #1;
        chk("mt_with_start_lo", bus.lo, 32'h0000_5555);

        // MTHI raised mid-MULT: held by stall, applied after the result lands
        wait_idle();
        prev_hi = bus.hi;
        issue(2'd0, 32'd3, 32'd5, 32'd0, 32'd15);
        repeat (4) @(negedge clk);
        bus.hilo_access = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234;
        #1;
        n = 0;
        while (bus.busy && n < 40) begin
            chk("mthi_stall", 32'(bus.stall), 32'd1);
            chk("mthi_hi_held", bus.hi, prev_hi);
            @(negedge clk);
            #1;
            n++;
        end
        chk("mthi_stall_released", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.hilo_access = 1'b0; bus.hi_we = 1'b0;
        chk("mthi_written", bus.hi, 32'h0000_1234);
        chk("mthi_lo_kept", bus.lo, 32'd15);
        m_hi = 32'h0000_1234;

        // start while busy is ignored; re-presented start then runs
        issue(2'd3, 32'd1000, 32'd10, 32'd0, 32'd100);
        bus.start = 1'b1; bus.op = 2'd0; bus.a = 32'd9; bus.b = 32'd9;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("b2b_stall", 32'(bus.stall), 32'd1);
            @(negedge clk);
            #1;
        end
        bus.start = 1'b0;
        wait_idle();
        issue(2'd0, 32'd9, 32'd9, 32'd0, 32'd81);

        // async reset in the middle of RUN
        issue(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0B00_EA4E, 32'h242D_2080);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_hi", bus.hi, 32'd0);
        chk("midrst_lo", bus.lo, 32'd0);
        sb.delete();
        m_hi = '0; m_lo = '0;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("postrst_idle", 32'(bus.busy), 32'd0);
        issue(2'd2, 32'd100, 32'hFFFF_FFFD, 32'd1, 32'hFFFF_FFDF);

        for (int i = 0; i < 500; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = pick();
            rb  = pick();
            r   = ref_model(rop, ra, rb);
            issue(rop, ra, rb, r[63:32], r[31:0]);
        end

        wait_idle();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        chk("final_hi", bus.hi, m_hi);
        chk("final_lo", bus.lo, m_lo);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
